// File: rtl/lsu_mem_bridge.sv
// Load/store bridge from the core's zero-latency data port to a req/ready/rvalid RAM.
// Handles lane steering, byte enables, load extension, misalignment and access timeout.
module lsu_mem_bridge #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              R_en,
  input  logic              W_en,
  input  logic [2:0]        RW_type,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic [31:0]       Wr_mem_data,
  output logic [31:0]       Rd_mem_data,
  output logic              stall,
  output logic              misalign,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R, S_DONE} state_t;

  localparam logic             TO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-3:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        type_q, type_d;
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              bus_err_q, bus_err_d;

  logic        req, is_b, is_h, mis, expired;
  logic [3:0]  be_new;
  logic [31:0] wd_new;

  // Lane extraction uses the latched type and byte offset, not the live core inputs.
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] t,
                                          input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*a +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (t)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b100:  extract = {24'b0, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b101:  extract = {16'b0, h};
      default: extract = w;
    endcase
  endfunction

  always_comb begin
    req     = rst_n & (R_en | W_en);
    is_b    = (RW_type[1:0] == 2'b00);
    is_h    = (RW_type[1:0] == 2'b01);
    mis     = is_h ? ram_addr[0] : (!is_b && (ram_addr[1:0] != 2'b00));
    expired = TO_EN && (cnt_q == TO_LAST);
    be_new  = 4'b1111;
    wd_new  = 32'h0;
    if (W_en) begin
      if (is_b) begin
        be_new = 4'b0001 << ram_addr[1:0];
        wd_new = {4{Wr_mem_data[7:0]}};
      end else if (is_h) begin
        be_new = ram_addr[1] ? 4'b1100 : 4'b0011;
        wd_new = {2{Wr_mem_data[15:0]}};
      end else begin
        wd_new = Wr_mem_data;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    type_d    = type_q;
    lane_d    = lane_q;
    rdata_d   = rdata_q;
    bus_err_d = 1'b0;
    stall     = 1'b0;
    misalign  = 1'b0;
    mem_req   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (mis) begin
            misalign = 1'b1;
          end else begin
            stall   = 1'b1;
            addr_d  = ram_addr[ADDR_W-1:2];
            we_d    = W_en;
            be_d    = be_new;
            wdata_d = wd_new;
            type_d  = RW_type;
            lane_d  = ram_addr[1:0];
            cnt_d   = '0;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        // Acceptance of a load without data is not a completion, so expiry still applies.
        if (mem_ready && we_q) begin
          state_d = S_DONE;
        end else if (mem_ready && mem_rvalid) begin
          rdata_d = extract(mem_rdata, type_q, lane_q);
          state_d = S_DONE;
        end else if (expired) begin
          bus_err_d = 1'b1;
          rdata_d   = 32'h0;
          state_d   = S_DONE;
        end else if (mem_ready) begin
          state_d = S_WAIT_R;
        end
      end
      S_WAIT_R: begin
        stall = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (mem_rvalid) begin
          rdata_d = extract(mem_rdata, type_q, lane_q);
          state_d = S_DONE;
        end else if (expired) begin
          bus_err_d = 1'b1;
          rdata_d   = 32'h0;
          state_d   = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      be_q      <= 4'b0;
      wdata_q   <= 32'h0;
      type_q    <= 3'b0;
      lane_q    <= 2'b0;
      rdata_q   <= 32'h0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      type_q    <= type_d;
      lane_q    <= lane_d;
      rdata_q   <= rdata_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign Rd_mem_data = rdata_q;
  assign bus_err     = bus_err_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_be      = be_q;
  assign mem_wdata   = wdata_q;

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Directed bench for lsu_mem_bridge: the bench acts as core and RAM, load results
// go through an expected queue and are popped when the bridge releases stall.
module tb_lsu_mem_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        R_en = 1'b0, W_en = 1'b0;
  logic [2:0]  RW_type = 3'b0;
  logic [31:0] ram_addr = 32'h0, Wr_mem_data = 32'h0;
  logic [31:0] Rd_mem_data;
  logic        stall, misalign, bus_err, mem_req, mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  lsu_mem_bridge #(.ADDR_W(32), .TIMEOUT_CYC(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .R_en(R_en), .W_en(W_en), .RW_type(RW_type),
    .ram_addr(ram_addr), .Wr_mem_data(Wr_mem_data), .Rd_mem_data(Rd_mem_data),
    .stall(stall), .misalign(misalign), .bus_err(bus_err), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  int          stall_n, req_n, mis_n, err_n;
  logic [3:0]  obs_be;
  logic [31:0] obs_wd;
  logic        obs_we;
  logic [29:0] obs_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Core + RAM driver: one access, RAM accepts after rdy_dly requesting cycles (-1 = never)
  // and returns data rv_dly cycles after acceptance.
  task automatic access(input logic r, input logic w, input logic [2:0] t,
                        input logic [31:0] a, input logic [31:0] d,
                        input int rdy_dly, input int rv_dly, input logic [31:0] word);
    int   acc_at;
    logic done;
    stall_n = 0; req_n = 0; mis_n = 0; err_n = 0;
    obs_be = 4'h0; obs_wd = 32'h0; obs_we = 1'b0; obs_addr = 30'h0;
    acc_at = -1;
    done   = 1'b0;
    @(negedge clk);
    R_en = r; W_en = w; RW_type = t; ram_addr = a; Wr_mem_data = d;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    for (int k = 0; k < 40 && !done; k++) begin
      if (k > 0) begin
        @(negedge clk);
        mem_ready = 1'b0; mem_rvalid = 1'b0;
      end
      #1;
      if (mem_req) begin
        if (rdy_dly >= 0 && req_n == rdy_dly) begin
          mem_ready = 1'b1;
          acc_at    = k;
          obs_be = mem_be; obs_wd = mem_wdata; obs_we = mem_we; obs_addr = mem_addr;
        end
        req_n++;
      end
      if (acc_at >= 0 && (k - acc_at) == rv_dly) begin
        mem_rvalid = 1'b1;
        mem_rdata  = word;
      end
      #1;
      if (misalign) mis_n++;
      if (bus_err) err_n++;
      if (stall) stall_n++;
      else done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL access_bound observed=stall_stuck expected=release addr=%h", a);
    end else if (exp_q.size() > 0) begin
      chk("rdata", Rd_mem_data, exp_q.pop_front());
    end
    @(negedge clk);
    R_en = 1'b0; W_en = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_rd", Rd_mem_data, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_req", {31'b0, mem_req}, 32'h0);
    chk("rst_be", {28'b0, mem_be}, 32'h0);
    rst_n = 1'b1;

    // sb 0xAB to 0x103, ready immediately
    access(1'b0, 1'b1, 3'b000, 32'h103, 32'h000000AB, 0, -1, 32'h0);
    chk("sb_be", {28'b0, obs_be}, 32'h8);
    chk("sb_wdata", obs_wd, 32'hABABABAB);
    chk("sb_we", {31'b0, obs_we}, 32'h1);
    chk("sb_addr", {2'b0, obs_addr}, 32'h40);
    chk("sb_stall", stall_n, 2);

    // sh 0x1234 to 0x102
    access(1'b0, 1'b1, 3'b001, 32'h102, 32'hFFFF1234, 0, -1, 32'h0);
    chk("sh_be", {28'b0, obs_be}, 32'hC);
    chk("sh_wdata", obs_wd, 32'h12341234);

    // lb / lbu from 0x102, rvalid three cycles after ready
    exp_q.push_back(32'hFFFFFFFF);
    access(1'b1, 1'b0, 3'b000, 32'h102, 32'h0, 0, 3, 32'h80FF7F00);
    chk("lb_stall", stall_n, 5);
    chk("lb_be", {28'b0, obs_be}, 32'hF);
    chk("lb_we", {31'b0, obs_we}, 32'h0);
    exp_q.push_back(32'h000000FF);
    access(1'b1, 1'b0, 3'b100, 32'h102, 32'h0, 0, 3, 32'h80FF7F00);
    chk("lbu_stall", stall_n, 5);

    // Other lanes and widths
    exp_q.push_back(32'hFFFF80FF);
    access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 0, 1, 32'h80FF7F00);
    exp_q.push_back(32'h000080FF);
    access(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 0, 1, 32'h80FF7F00);
    exp_q.push_back(32'h0000007F);
    access(1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 0, 0, 32'h80FF7F00);
    exp_q.push_back(32'hFFFFFF85);
    access(1'b1, 1'b0, 3'b000, 32'h200, 32'h0, 0, 0, 32'h12345685);

    // Minimum-latency lw
    exp_q.push_back(32'h80FF7F00);
    access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 32'h80FF7F00);
    chk("lw_min_stall", stall_n, 2);

    // Ready delayed by two request cycles
    exp_q.push_back(32'hA5A55A5A);
    access(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 2, 0, 32'hA5A55A5A);
    chk("lw_dly_stall", stall_n, 4);
    chk("lw_dly_req", req_n, 3);
    chk("lw_dly_addr", {2'b0, obs_addr}, 32'h41);

    // Timeout: ready never comes
    exp_q.push_back(32'h0);
    access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, -1, -1, 32'h0);
    chk("to_req", req_n, 4);
    chk("to_err", err_n, 1);
    chk("to_stall", stall_n, 5);

    // Misaligned lh and lw: no bus access, no stall
    exp_q.push_back(32'h0);
    access(1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 0, 0, 32'hFFFFFFFF);
    chk("mis_h_pulse", mis_n, 1);
    chk("mis_h_req", req_n, 0);
    chk("mis_h_stall", stall_n, 0);
    access(1'b1, 1'b0, 3'b010, 32'h42, 32'h0, 0, 0, 32'hFFFFFFFF);
    chk("mis_w_pulse", mis_n, 1);
    chk("mis_w_req", req_n, 0);

    // Simultaneous R_en and W_en: store wins
    access(1'b1, 1'b1, 3'b010, 32'h10, 32'h12345678, 0, -1, 32'h0);
    chk("rw_we", {31'b0, obs_we}, 32'h1);
    chk("rw_be", {28'b0, obs_be}, 32'hF);
    chk("rw_wdata", obs_wd, 32'h12345678);
    chk("rw_mis", mis_n, 0);

    exp_q.push_back(32'h11223344);
    access(1'b1, 1'b0, 3'b010, 32'h30, 32'h0, 0, 0, 32'h11223344);

    // Reset while waiting for read data
    @(negedge clk);
    R_en = 1'b1; RW_type = 3'b010; ram_addr = 32'h20;
    @(negedge clk);
    #1;
    chk("wr_req", {31'b0, mem_req}, 32'h1);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("wr_wait_stall", {31'b0, stall}, 32'h1);
    chk("wr_wait_req", {31'b0, mem_req}, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("wr_rst_stall", {31'b0, stall}, 32'h0);
    chk("wr_rst_rd", Rd_mem_data, 32'h0);
    chk("wr_rst_addr", {2'b0, mem_addr}, 32'h0);
    chk("wr_rst_wdata", mem_wdata, 32'h0);
    R_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    chk("late_rv_rd", Rd_mem_data, 32'h0);
    chk("late_rv_stall", {31'b0, stall}, 32'h0);
    chk("late_rv_req", {31'b0, mem_req}, 32'h0);

    exp_q.push_back(32'hCAFEF00D);
    access(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 0, 1, 32'hCAFEF00D);
    chk("post_rst_stall", stall_n, 3);

    chk("exp_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
